control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hardwired Mini SRC control sequencer: drives every enable/select input of `datapath`, replacing hand-driven benches.
//  Fetches at PC, decodes IR[31:27], steps one control state per clock, then returns to fetch.
//  Sits directly upstream of `datapath`; consumes its IR and CON flag.
// PARAMETERS
//  CNT_W  16  width of retired-instruction counter (wraps)
// PORTS
//  clock          in   1   system clock, rising edge
//  clear          in   1   asynchronous, active-high reset
//  stop           in   1   request halt at next instruction boundary
//  IR             in   32  datapath instruction register
//  CON            in   1   datapath branch-condition flip-flop output
//  incPC,e_PC,e_IR,e_Y,e_Z,e_MAR,e_MDR,MDR_read  out 1  datapath enables
//  ram_read,ram_write                              out 1  memory strobes
//  Gra,Grb,Grc,e_Rin,e_Rout,BAout,imm_sel,e_CON_FF out 1  register/ALU selects
//  ALU_op         out  4   ALU operation
//  BusDataSelect  out  5   bus source
//  run            out  1   1 while executing, 0 when halted
//  illegal        out  1   sticky: undefined opcode decoded
//  retired        out  CNT_W instructions completed
// BEHAVIOUR
//  Reset: state=F0; all enables/strobes 0; ALU_op=0, BusDataSelect=BUS_NONE; run=1, illegal=0, retired=0.
//  All control outputs are combinational in (state, IR, CON). The datapath latches at the posedge ending each state.
//  Bus codes: NONE 00000, GP 00001, ZLO 10011, PC 10100, MDR 10101, C 11000. ALU ADD=0011.
//  Fetch:
//   F0: BUS=PC, e_MAR, incPC
//   F1: ram_read
//   F2: MDR_read, e_MDR
//   F3: BUS=MDR, e_IR
//   DEC: no enables; branch on opcode
//  ldi (8 cycles total):
//   E3: Grb, BAout, e_Y
//   E4: imm_sel, ADD, e_Z
//   E5: BUS=ZLO, Gra, e_Rin
//  ld (11): E3-E4 as ldi, then
//   E5: BUS=ZLO, e_MAR
//   E6: ram_read
//   E7: MDR_read, e_MDR
//   E8: BUS=MDR, Gra, e_Rin
//  st (10): E3-E5 as ld, then
//   E6: BUS=GP, Gra, e_Rout, e_MDR (MDR_read=0)
//   E7: ram_write
//  R-type ALU (8):
//   E3: BUS=GP, Grb, e_Rout, e_Y
//   E4: BUS=GP, Grc, e_Rout, ALU_op=alu_map(opcode), e_Z
//   E5: BUS=ZLO, Gra, e_Rin
//  I-type ALU (8): as R-type, but E4 has imm_sel=1 and Grc/e_Rout=0.
//  br (9):
//   E3: BUS=GP, Gra, e_Rout, e_CON_FF
//   E4: BUS=PC, e_Y
//   E5: imm_sel, ADD, e_Z
//   E6: if CON: BUS=ZLO, e_PC; else idle
//   CON is sampled in E6 only. PC already holds PC+1 from F0.
//  nop: DEC->F0.
//  halt: DEC->HALT; run=0; outputs idle until clear.
//  Undefined opcode: sets illegal, then executes as nop.
//  Last state of each instruction: retired+=1 (wraps at 2^CNT_W). Next state is F0, or HALT if stop=1 that cycle.
//  clear mid-instruction: immediate return to F0, all outputs idle in the same cycle (async). No partial write completes after clear.
//  Only one of e_PC/incPC is ever high in a cycle. ram_read and ram_write are never high together.
// STRUCTURE
//  Package mini_src_pkg: opcode constants, BUS_* codes, ALU_* codes, state enum typedef.
//  Sub-module control_decode (combinational): opcode -> {class, alu_op, illegal}.
//  control_unit holds the state register, the counter, and output decode.
// TESTING
//  1. Mem[0]=ldi R2,0x78; release clear -> R2=0x00000078 at end of cycle 8; retired=1; PC=1.
//  2. ldi R2,0x78; ld R6,0x63(R2); Mem[0xDB]=0xCAFE -> R6=0x0000CAFE; retired=2 after 19 cycles.
//  3. R2=0 with brzr R2,+5 at PC=1 -> PC=7. Same with R2=1 -> PC=2; e_PC never asserted.
//  4. st R6,0x10(R0), R6=0x1234 -> Mem[0x10]=0x1234; ram_write high exactly 1 cycle.
//  5. halt, or stop raised during add -> add completes, run=0, no further ram_read.
//     Undefined opcode -> illegal=1, PC advances by 1.
//  6. Assert clear during ld E6 -> state F0 and all outputs 0 immediately; rerun yields the same result as test 2.

Source files
------------

// File: rtl/mini_src_pkg.sv
// Mini SRC shared definitions: opcode encodings, bus source codes, ALU operation
// codes, control-sequencer state and instruction-class enums.
// No ports.
package mini_src_pkg;

    // Opcodes (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Bus source selects
    localparam logic [4:0] BUS_NONE = 5'b00000;
    localparam logic [4:0] BUS_GP   = 5'b00001;
    localparam logic [4:0] BUS_ZLO  = 5'b10011;
    localparam logic [4:0] BUS_PC   = 5'b10100;
    localparam logic [4:0] BUS_MDR  = 5'b10101;
    localparam logic [4:0] BUS_C    = 5'b11000;

    // ALU operations; R-type ALU opcodes map onto these through their low nibble
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;

    typedef enum logic [3:0] {
        StF0, StF1, StF2, StF3, StDec,
        StE3, StE4, StE5, StE6, StE7, StE8,
        StHalt
    } state_t;

    typedef enum logic [2:0] {
        ClsNop, ClsLd, ClsLdi, ClsSt, ClsAlu, ClsAluImm, ClsBr, ClsHalt
    } instr_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder for the Mini SRC control sequencer.
// Ports:
//   opcode  in   5  IR[31:27]
//   iclass  out     instruction class (undefined opcodes report ClsNop)
//   alu_op  out  4  ALU operation for ALU-class instructions
//   illegal out  1  opcode is not defined
module control_decode
    import mini_src_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t iclass,
    output logic [3:0]   alu_op,
    output logic         illegal
);

    always_comb begin
        iclass  = ClsNop;
        alu_op  = ALU_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_LD:   iclass = ClsLd;
            OP_LDI:  iclass = ClsLdi;
            OP_ST:   iclass = ClsSt;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                iclass = ClsAlu;
                alu_op = opcode[3:0];
            end
            OP_ADDI: begin
                iclass = ClsAluImm;
                alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                iclass = ClsAluImm;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                iclass = ClsAluImm;
                alu_op = ALU_OR;
            end
            OP_BR:   iclass = ClsBr;
            OP_NOP:  iclass = ClsNop;
            OP_HALT: iclass = ClsHalt;
            default: illegal = 1'b1;   // executes as nop
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer. Fetches, decodes IR[31:27] and steps one
// control state per clock, driving every datapath enable/select.
// Ports:
//   clock, clear (async active-high), stop (halt at next instruction boundary)
//   IR, CON                  from datapath
//   incPC..e_CON_FF          datapath enables, memory strobes, register selects
//   ALU_op, BusDataSelect    ALU operation and bus source
//   run, illegal, retired    status: executing, sticky undefined-opcode, count
module control_unit
    import mini_src_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             stop,
    input  logic [31:0]      IR,
    input  logic             CON,
    output logic             incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read,
    output logic             ram_read, ram_write,
    output logic             Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, e_CON_FF,
    output logic [3:0]       ALU_op,
    output logic [4:0]       BusDataSelect,
    output logic             run,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t       state, state_n;
    instr_class_t cls;
    logic [3:0]   dec_alu_op;
    logic         dec_illegal;
    logic         last;
    logic         illegal_flag;

    // Only the opcode field steers the sequencer.
    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    control_decode u_decode (
        .opcode  (IR[31:27]),
        .iclass  (cls),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    // Last state of each instruction; halt retires at DEC like nop.
    always_comb begin
        case (state)
            StDec:   last = (cls == ClsNop) || (cls == ClsHalt);
            StE5:    last = (cls == ClsLdi) || (cls == ClsAlu) || (cls == ClsAluImm);
            StE6:    last = (cls == ClsBr);
            StE7:    last = (cls == ClsSt);
            StE8:    last = (cls == ClsLd);
            default: last = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        if (last) begin
            state_n = (stop || (cls == ClsHalt)) ? StHalt : StF0;
        end else begin
            case (state)
                StF0:    state_n = StF1;
                StF1:    state_n = StF2;
                StF2:    state_n = StF3;
                StF3:    state_n = StDec;
                StDec:   state_n = StE3;
                StE3:    state_n = StE4;
                StE4:    state_n = StE5;
                StE5:    state_n = StE6;
                StE6:    state_n = StE7;
                StE7:    state_n = StE8;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= StF0;
            illegal_flag <= 1'b0;
            retired      <= '0;
        end else begin
            state <= state_n;
            if ((state == StDec) && dec_illegal) illegal_flag <= 1'b1;
            if (last) retired <= retired + CNT_W'(1);
        end
    end

    assign run     = (state != StHalt);
    assign illegal = illegal_flag;

    // Outputs are gated by clear so an aborted instruction cannot finish a write.
    always_comb begin
        {incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read} = '0;
        {ram_read, ram_write} = '0;
        {Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, e_CON_FF} = '0;
        ALU_op        = ALU_NONE;
        BusDataSelect = BUS_NONE;
        if (!clear) begin
            case (state)
                StF0: begin BusDataSelect = BUS_PC; e_MAR = 1'b1; incPC = 1'b1; end
                StF1: ram_read = 1'b1;
                StF2: begin MDR_read = 1'b1; e_MDR = 1'b1; end
                StF3: begin BusDataSelect = BUS_MDR; e_IR = 1'b1; end
                StE3: begin
                    case (cls)
                        ClsLd, ClsLdi, ClsSt: begin Grb = 1'b1; BAout = 1'b1; e_Y = 1'b1; end
                        ClsAlu, ClsAluImm: begin
                            BusDataSelect = BUS_GP; Grb = 1'b1; e_Rout = 1'b1; e_Y = 1'b1;
                        end
                        ClsBr: begin
                            BusDataSelect = BUS_GP; Gra = 1'b1; e_Rout = 1'b1; e_CON_FF = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StE4: begin
                    case (cls)
                        ClsLd, ClsLdi, ClsSt: begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
                        ClsAlu: begin
                            BusDataSelect = BUS_GP; Grc = 1'b1; e_Rout = 1'b1;
                            ALU_op = dec_alu_op; e_Z = 1'b1;
                        end
                        ClsAluImm: begin
                            BusDataSelect = BUS_GP; imm_sel = 1'b1; ALU_op = dec_alu_op; e_Z = 1'b1;
                        end
                        ClsBr: begin BusDataSelect = BUS_PC; e_Y = 1'b1; end
                        default: ;
                    endcase
                end
                StE5: begin
                    case (cls)
                        ClsLdi, ClsAlu, ClsAluImm: begin
                            BusDataSelect = BUS_ZLO; Gra = 1'b1; e_Rin = 1'b1;
                        end
                        ClsLd, ClsSt: begin BusDataSelect = BUS_ZLO; e_MAR = 1'b1; end
                        ClsBr: begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
                        default: ;
                    endcase
                end
                StE6: begin
                    case (cls)
                        ClsLd: ram_read = 1'b1;
                        ClsSt: begin
                            BusDataSelect = BUS_GP; Gra = 1'b1; e_Rout = 1'b1; e_MDR = 1'b1;
                        end
                        ClsBr: if (CON) begin BusDataSelect = BUS_ZLO; e_PC = 1'b1; end
                        default: ;
                    endcase
                end
                StE7: begin
                    if (cls == ClsLd) begin MDR_read = 1'b1; e_MDR = 1'b1; end
                    if (cls == ClsSt) ram_write = 1'b1;
                end
                StE8: if (cls == ClsLd) begin BusDataSelect = BUS_MDR; Gra = 1'b1; e_Rin = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the expected control word of
// every cycle of each instruction; a negedge monitor pops and compares.
module tb_control_unit;

    localparam int unsigned CNT_W = 16;

    logic clock = 1'b0;
    logic clear, stop, CON;
    logic [31:0] IR;
    logic incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, ram_write;
    logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, e_CON_FF;
    logic [3:0] ALU_op;
    logic [4:0] BusDataSelect;
    logic run, illegal;
    logic [CNT_W-1:0] retired;

    control_unit #(.CNT_W(CNT_W)) dut (
        .clock(clock), .clear(clear), .stop(stop), .IR(IR), .CON(CON),
        .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_MAR(e_MAR),
        .e_MDR(e_MDR), .MDR_read(MDR_read), .ram_read(ram_read), .ram_write(ram_write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout),
        .imm_sel(imm_sel), .e_CON_FF(e_CON_FF), .ALU_op(ALU_op),
        .BusDataSelect(BusDataSelect), .run(run), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    // Enable bit positions within the 18-bit flag field
    localparam logic [17:0] INC  = 18'h20000, EPC  = 18'h10000, EIR  = 18'h08000;
    localparam logic [17:0] EY   = 18'h04000, EZ   = 18'h02000, EMAR = 18'h01000;
    localparam logic [17:0] EMDR = 18'h00800, MDRR = 18'h00400, RR   = 18'h00200;
    localparam logic [17:0] RW   = 18'h00100, GRA  = 18'h00080, GRB  = 18'h00040;
    localparam logic [17:0] GRC  = 18'h00020, RIN  = 18'h00010, ROUT = 18'h00008;
    localparam logic [17:0] BA   = 18'h00004, IMM  = 18'h00002, ECON = 18'h00001;
    localparam logic [17:0] NOEN = 18'h00000;

    localparam logic [4:0] B_NONE = 5'b00000, B_GP = 5'b00001, B_ZLO = 5'b10011;
    localparam logic [4:0] B_PC = 5'b10100, B_MDR = 5'b10101;
    localparam logic [3:0] A_NONE = 4'b0000, A_ADD = 4'b0011;

    localparam logic [31:0] I_LDI   = {5'b00001, 4'd2, 4'd0, 19'h78};
    localparam logic [31:0] I_LD    = {5'b00000, 4'd6, 4'd2, 19'h63};
    localparam logic [31:0] I_BRZR  = {5'b10011, 4'd2, 4'd0, 19'h5};
    localparam logic [31:0] I_ST    = {5'b00010, 4'd6, 4'd0, 19'h10};
    localparam logic [31:0] I_ADD   = {5'b00011, 4'd3, 4'd4, 4'd5, 15'h0};
    localparam logic [31:0] I_ADDI  = {5'b01100, 4'd3, 4'd4, 19'h7};
    localparam logic [31:0] I_NOP   = {5'b11010, 27'h0};
    localparam logic [31:0] I_HALT  = {5'b11011, 27'h0};
    localparam logic [31:0] I_UNDEF = {5'b11111, 27'h0};

    localparam int K_LDI = 0, K_LD = 1, K_ST = 2, K_ADD = 3, K_ADDI = 4, K_BR = 5, K_NOP = 6;

    typedef struct {
        logic [26:0] w;
        logic        run;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_idx = 0;
    int   checks = 0;
    int   failures = 0;

    logic [26:0] act;
    assign act = {BusDataSelect, ALU_op, incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read,
                  ram_read, ram_write, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, e_CON_FF};

    function automatic logic [26:0] cw(input logic [4:0] b, input logic [3:0] a,
                                       input logic [17:0] e);
        return {b, a, e};
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [26:0] w, input logic r);
        exp_t e;
        e.w   = w;
        e.run = r;
        sb.push_back(e);
    endtask

    task automatic push_fetch();
        push(cw(B_PC, A_NONE, INC | EMAR), 1'b1);
        push(cw(B_NONE, A_NONE, RR), 1'b1);
        push(cw(B_NONE, A_NONE, MDRR | EMDR), 1'b1);
        push(cw(B_MDR, A_NONE, EIR), 1'b1);
        push(cw(B_NONE, A_NONE, NOEN), 1'b1);
    endtask

    // Fetch, DEC and E3-E5 of ld/st (address computation into MAR)
    task automatic push_addr_head();
        push_fetch();
        push(cw(B_NONE, A_NONE, GRB | BA | EY), 1'b1);
        push(cw(B_NONE, A_ADD, IMM | EZ), 1'b1);
        push(cw(B_ZLO, A_NONE, EMAR), 1'b1);
    endtask

    task automatic expect_instr(input int k, input logic con_v);
        case (k)
            K_LDI: begin
                push_fetch();
                push(cw(B_NONE, A_NONE, GRB | BA | EY), 1'b1);
                push(cw(B_NONE, A_ADD, IMM | EZ), 1'b1);
                push(cw(B_ZLO, A_NONE, GRA | RIN), 1'b1);
            end
            K_LD: begin
                push_addr_head();
                push(cw(B_NONE, A_NONE, RR), 1'b1);
                push(cw(B_NONE, A_NONE, MDRR | EMDR), 1'b1);
                push(cw(B_MDR, A_NONE, GRA | RIN), 1'b1);
            end
            K_ST: begin
                push_addr_head();
                push(cw(B_GP, A_NONE, GRA | ROUT | EMDR), 1'b1);
                push(cw(B_NONE, A_NONE, RW), 1'b1);
            end
            K_ADD, K_ADDI: begin
                push_fetch();
                push(cw(B_GP, A_NONE, GRB | ROUT | EY), 1'b1);
                if (k == K_ADD) push(cw(B_GP, A_ADD, GRC | ROUT | EZ), 1'b1);
                else            push(cw(B_GP, A_ADD, IMM | EZ), 1'b1);
                push(cw(B_ZLO, A_NONE, GRA | RIN), 1'b1);
            end
            K_BR: begin
                push_fetch();
                push(cw(B_GP, A_NONE, GRA | ROUT | ECON), 1'b1);
                push(cw(B_PC, A_NONE, EY), 1'b1);
                push(cw(B_NONE, A_ADD, IMM | EZ), 1'b1);
                if (con_v) push(cw(B_ZLO, A_NONE, EPC), 1'b1);
                else       push(cw(B_NONE, A_NONE, NOEN), 1'b1);
            end
            default: push_fetch();
        endcase
    endtask

    task automatic do_instr(input logic [31:0] ir, input logic con_v, input logic stop_v,
                            input int n);
        IR   = ir;
        CON  = con_v;
        stop = stop_v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_idle(input int n);
        stop = 1'b0;
        repeat (n) push(cw(B_NONE, A_NONE, NOEN), 1'b0);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic release_clear();
        @(posedge clock);
        #2;
        clear = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!clear) begin
            check("pc_excl", 32'(incPC & e_PC), 32'd0);
            check("ram_excl", 32'(ram_read & ram_write), 32'd0);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check($sformatf("ctrl#%0d", mon_idx), 32'(act), 32'(mon_e.w));
                check($sformatf("run#%0d", mon_idx), 32'(run), 32'(mon_e.run));
                mon_idx++;
            end
        end
    end

    initial begin
        clear = 1'b1;
        stop  = 1'b0;
        CON   = 1'b0;
        IR    = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", 32'(act), 32'd0);
        check("reset_run", 32'(run), 32'd1);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_retired", 32'(retired), 32'd0);

        expect_instr(K_LDI, 1'b0);
        release_clear();
        do_instr(I_LDI, 1'b0, 1'b0, 8);
        check("ldi_retired", 32'(retired), 32'd1);
        expect_instr(K_LD, 1'b0);
        do_instr(I_LD, 1'b0, 1'b0, 11);
        check("ld_retired", 32'(retired), 32'd2);
        expect_instr(K_BR, 1'b1);
        do_instr(I_BRZR, 1'b1, 1'b0, 9);
        expect_instr(K_BR, 1'b0);
        do_instr(I_BRZR, 1'b0, 1'b0, 9);
        check("br_retired", 32'(retired), 32'd4);
        expect_instr(K_ST, 1'b0);
        do_instr(I_ST, 1'b0, 1'b0, 10);
        expect_instr(K_ADD, 1'b0);
        do_instr(I_ADD, 1'b0, 1'b0, 8);
        expect_instr(K_ADDI, 1'b0);
        do_instr(I_ADDI, 1'b0, 1'b0, 8);
        expect_instr(K_NOP, 1'b0);
        do_instr(I_NOP, 1'b0, 1'b0, 5);
        check("nop_retired", 32'(retired), 32'd8);
        check("illegal_before", 32'(illegal), 32'd0);
        expect_instr(K_NOP, 1'b0);
        do_instr(I_UNDEF, 1'b0, 1'b0, 5);
        check("illegal_set", 32'(illegal), 32'd1);
        check("undef_retired", 32'(retired), 32'd9);

        // stop raised during add: add completes, then halt
        expect_instr(K_ADD, 1'b0);
        do_instr(I_ADD, 1'b0, 1'b1, 8);
        check("stop_retired", 32'(retired), 32'd10);
        check("stop_run", 32'(run), 32'd0);
        do_idle(3);
        check("illegal_sticky", 32'(illegal), 32'd1);

        clear = 1'b1;
        #1;
        check("clear_run", 32'(run), 32'd1);
        check("clear_illegal", 32'(illegal), 32'd0);
        check("clear_retired", 32'(retired), 32'd0);

        // halt opcode
        expect_instr(K_NOP, 1'b0);
        release_clear();
        do_instr(I_HALT, 1'b0, 1'b0, 5);
        check("halt_run", 32'(run), 32'd0);
        check("halt_retired", 32'(retired), 32'd1);
        do_idle(2);

        // clear during ld E6 aborts the load
        clear = 1'b1;
        #1;
        expect_instr(K_LDI, 1'b0);
        release_clear();
        do_instr(I_LDI, 1'b0, 1'b0, 8);
        push_addr_head();
        do_instr(I_LD, 1'b0, 1'b0, 8);
        check("e6_ram_read", 32'(ram_read), 32'd1);
        clear = 1'b1;
        #1;
        check("abort_ctrl", 32'(act), 32'd0);
        check("abort_run", 32'(run), 32'd1);
        check("abort_retired", 32'(retired), 32'd0);
        expect_instr(K_LDI, 1'b0);
        release_clear();
        do_instr(I_LDI, 1'b0, 1'b0, 8);
        expect_instr(K_LD, 1'b0);
        do_instr(I_LD, 1'b0, 1'b0, 11);
        check("rerun_retired", 32'(retired), 32'd2);

        repeat (2) @(posedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
